// File: rtl/fpalu_pkg.sv
// rtl/fpalu_pkg.sv - shared constants, FSM states and unpacked-float type for the fpalu datapath
package fpalu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADDSUB,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  // Signed infinity encoding
  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, EXP_MAX, {MAN_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fpalu_unpack.sv
// rtl/fpalu_unpack.sv - combinational field extraction, denormal flush and NaN/Inf/zero classification
module fpalu_unpack
  import fpalu_pkg::*;
(
  input  logic [31:0]    x,
  output fp_t            f,
  output logic [MAN_W:0] sig,
  output logic           is_nan,
  output logic           is_inf,
  output logic           is_zero
);

  fp_t raw;
  assign raw = x;

  // Classify the raw encoding, then flush denormals to a signed zero with no hidden bit
  always_comb begin
    is_zero = (raw.exp == '0);
    is_nan  = (raw.exp == EXP_MAX) && (raw.man != '0);
    is_inf  = (raw.exp == EXP_MAX) && (raw.man == '0);
    f       = raw;
    if (is_zero) begin
      f.exp = '0;
      f.man = '0;
    end
    sig = {~is_zero, f.man};
  end

endmodule

// File: rtl/fpalu_sub_seq.sv
// rtl/fpalu_sub_seq.sv - multi-cycle IEEE-754 single subtractor d = a - b; FPALU_SUB_ADD_MODE_EN adds an op port
module fpalu_sub_seq
  import fpalu_pkg::*;
#(
  parameter int GUARD_BITS = 3
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef FPALU_SUB_ADD_MODE_EN
  input  logic        op,
`endif
  output logic [31:0] d,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  // Significand width: hidden bit + fraction + guard/round/sticky
  localparam int SW = MAN_W + 1 + GUARD_BITS;
  // Exponent carried with headroom for the carry increment
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] MAX_SH = EXP_W'(SW - 1);

  logic neg_b;
`ifdef FPALU_SUB_ADD_MODE_EN
  assign neg_b = op;
`else
  assign neg_b = 1'b1;
`endif

  state_t         state;
  logic [31:0]    ra, rb;
  logic           sx, sy;
  logic [EW-1:0]  ex;
  logic [EXP_W-1:0] ey;
  logic [SW-1:0]  mx, my;
  logic [SW:0]    sig;
  logic           special_r;
  logic [31:0]    res;
  logic           res_ovf;

  fp_t            fa, fb;
  logic [MAN_W:0] siga, sigb;
  logic           nan_a, inf_a, zero_a;
  logic           nan_b, inf_b, zero_b;

  fpalu_unpack u_unpack_a (
    .x       (ra),
    .f       (fa),
    .sig     (siga),
    .is_nan  (nan_a),
    .is_inf  (inf_a),
    .is_zero (zero_a)
  );

  fpalu_unpack u_unpack_b (
    .x       (rb),
    .f       (fb),
    .sig     (sigb),
    .is_nan  (nan_b),
    .is_inf  (inf_b),
    .is_zero (zero_b)
  );

  logic        a_ge_b;
  logic        is_special;
  logic [31:0] special_res;

  // Magnitude ordering and special-operand resolution (rb already carries the effective sign)
  always_comb begin
    a_ge_b      = zero_b || (!zero_a && ({fa.exp, fa.man} >= {fb.exp, fb.man}));
    is_special  = 1'b1;
    special_res = QNAN;
    if (nan_a || nan_b) begin
      special_res = QNAN;
    end else if (inf_a && inf_b) begin
      special_res = (fa.sign != fb.sign) ? QNAN : fp_inf(fa.sign);
    end else if (inf_a) begin
      special_res = fp_inf(fa.sign);
    end else if (inf_b) begin
      special_res = fp_inf(fb.sign);
    end else begin
      is_special = 1'b0;
    end
  end

  logic [EXP_W-1:0] sh;
  logic [SW-1:0]    lost_mask;
  logic [SW-1:0]    my_al;

  // Right-align the smaller operand; everything shifted out collapses into the sticky LSB
  always_comb begin
    sh        = ex[EXP_W-1:0] - ey;
    lost_mask = ~({SW{1'b1}} << sh);
    my_al     = my >> sh;
    if (sh > MAX_SH) begin
      my_al = {{(SW-1){1'b0}}, |my};
    end else begin
      my_al[0] = my_al[0] | (|(my & lost_mask));
    end
  end

  logic [SW:0]   sum, sum_n;
  logic [EW-1:0] ex_n;
  logic          norm_done;

  // Magnitude add/subtract, carry renormalisation and the skip-NORM decision
  always_comb begin
    sum = (sx == sy) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    if (sum[SW]) begin
      sum_n = {1'b0, sum[SW:2], sum[1] | sum[0]};
      ex_n  = ex + EW'(1);
    end else begin
      sum_n = sum;
      ex_n  = ex;
    end
    norm_done = sum_n[SW-1] || (sum_n == '0) || (ex_n <= EW'(1));
  end

  logic [SW:0]   sig_sh;
  logic [EW-1:0] ex_dec;
  logic          norm_last;

  // One left-shift normalisation step
  always_comb begin
    sig_sh    = sig << 1;
    ex_dec    = ex - EW'(1);
    norm_last = sig_sh[SW-1] || (ex_dec <= EW'(1));
  end

  logic [31:0] pack_res;
  logic        pack_ovf;

  // Truncate guard bits and encode zero, overflow and underflow results
  always_comb begin
    pack_ovf = 1'b0;
    if (sig == '0) begin
      pack_res = 32'h0000_0000;
    end else if (ex >= EW'(255)) begin
      pack_res = fp_inf(sx);
      pack_ovf = 1'b1;
    end else if (!sig[SW-1]) begin
      pack_res = {sx, 31'd0};
    end else begin
      pack_res = {sx, ex[EXP_W-1:0], sig[SW-2:GUARD_BITS]};
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      d         <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      ex        <= '0;
      ey        <= '0;
      mx        <= '0;
      my        <= '0;
      sig       <= '0;
      special_r <= 1'b0;
      res       <= '0;
      res_ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= {b[31] ^ neg_b, b[30:0]};
            busy  <= 1'b1;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          special_r <= is_special;
          res       <= special_res;
          res_ovf   <= 1'b0;
          if (a_ge_b) begin
            sx <= fa.sign;
            ex <= {2'b00, fa.exp};
            mx <= {siga, {GUARD_BITS{1'b0}}};
            sy <= fb.sign;
            ey <= fb.exp;
            my <= {sigb, {GUARD_BITS{1'b0}}};
          end else begin
            sx <= fb.sign;
            ex <= {2'b00, fb.exp};
            mx <= {sigb, {GUARD_BITS{1'b0}}};
            sy <= fa.sign;
            ey <= fa.exp;
            my <= {siga, {GUARD_BITS{1'b0}}};
          end
          state <= is_special ? S_PACK : S_ALIGN;
        end
        S_ALIGN: begin
          my    <= my_al;
          state <= S_ADDSUB;
        end
        S_ADDSUB: begin
          sig   <= sum_n;
          ex    <= ex_n;
          state <= norm_done ? S_PACK : S_NORM;
        end
        S_NORM: begin
          sig <= sig_sh;
          ex  <= ex_dec;
          if (norm_last) begin
            state <= S_PACK;
          end
        end
        S_PACK: begin
          if (!special_r) begin
            res     <= pack_res;
            res_ovf <= pack_ovf;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          d        <= res;
          overflow <= res_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpalu_sub_seq.sv
// tb/tb_fpalu_sub_seq.sv - directed and randomized self-checking bench for fpalu_sub_seq
module tb_fpalu_sub_seq;
  import fpalu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b, d;
  logic        overflow, busy, done;
`ifdef FPALU_SUB_ADD_MODE_EN
  logic        op;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpalu_sub_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef FPALU_SUB_ADD_MODE_EN
    .op       (op),
`endif
    .d        (d),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  localparam int NDIR = 8;
  logic [31:0] dir_a [NDIR] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                                32'h7F7FFFFF, 32'h7F800000, 32'hFFC00000, 32'h3F800001};
  logic [31:0] dir_b [NDIR] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h33000000,
                                32'hFF7FFFFF, 32'h7F800000, 32'h12345678, 32'h3F800000};
  logic [31:0] dir_d [NDIR] = '{32'h00000000, 32'h40000000, 32'hBF800000, 32'h3F7FFFFF,
                                32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h34000000};
  logic        dir_ov [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int          dir_lat [NDIR] = '{6, 6, 7, 7, 6, 4, 4, 29};

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic real to_real(input logic [31:0] v);
    logic [63:0] bits;
    if (v[30:23] == 8'd0) return 0.0;
    bits = {v[31], 11'(v[30:23]) + 11'(1023 - BIAS), v[22:0], 29'd0};
    return $bitstoreal(bits);
  endfunction

  // Reference: returns {overflow, d}; exact real difference truncated toward zero
  function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic [7:0]  ex_, ey_;
    logic        sa, sb;
    logic [31:0] big;
    logic [63:0] rbits;
    real         r;
    int          e;
    ex_ = x[30:23];
    ey_ = y[30:23];
    sa  = x[31];
    sb  = ~y[31];
    if ((ex_ == 8'hFF && x[22:0] != 0) || (ey_ == 8'hFF && y[22:0] != 0)) return {1'b0, QNAN};
    if (ex_ == 8'hFF && ey_ == 8'hFF) return (sa != sb) ? {1'b0, QNAN} : {1'b0, x};
    if (ex_ == 8'hFF) return {1'b0, x};
    if (ey_ == 8'hFF) return {1'b0, sb, y[30:0]};
    if (ex_ != 0 && ey_ != 0 && (int'(ex_) - int'(ey_) > 28 || int'(ey_) - int'(ex_) > 28)) begin
      big = (ex_ > ey_) ? x : {sb, y[30:0]};
      return (sa == sb) ? {1'b0, big} : {1'b0, big - 32'd1};
    end
    r = to_real(x) - to_real(y);
    if (r == 0.0) return 33'd0;
    rbits = $realtobits(r);
    e = int'(rbits[62:52]) - 1023 + BIAS;
    if (e >= 255) return {1'b1, rbits[63], 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, rbits[63], 31'd0};
    return {1'b0, rbits[63], e[7:0], rbits[51:29]};
  endfunction

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output int lat, output logic [31:0] od, output logic ov);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check32("timeout", {31'd0, done}, 32'd1);
    od = d;
    ov = overflow;
  endtask

  initial begin
    int          lat, ndone, mode, ea, eb;
    logic [31:0] od, x, y;
    logic        ov;
    logic [32:0] m;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef FPALU_SUB_ADD_MODE_EN
    op = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check32("rst_d", d, 32'd0);
    check32("rst_ovf", {31'd0, overflow}, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NDIR; i++) begin
      run_op(dir_a[i], dir_b[i], lat, od, ov);
      check32($sformatf("dir%0d_d", i), od, dir_d[i]);
      check32($sformatf("dir%0d_ovf", i), {31'd0, ov}, {31'd0, dir_ov[i]});
      check32($sformatf("dir%0d_lat", i), 32'(lat), 32'(dir_lat[i]));
    end

    for (int i = 0; i < 60; i++) begin
      mode = int'($urandom_range(0, 3));
      ea = int'($urandom_range(1, 254));
      case (mode)
        0: eb = ea + int'($urandom_range(0, 56)) - 28;
        1: eb = int'($urandom_range(0, 255));
        2: eb = ea;
        default: begin
          ea = int'($urandom_range(250, 254));
          eb = int'($urandom_range(250, 254));
        end
      endcase
      if (mode != 1) begin
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
      end
      x = {1'($urandom), 8'(ea), 23'($urandom)};
      y = {1'($urandom), 8'(eb), 23'($urandom)};
      m = ref_sub(x, y);
      run_op(x, y, lat, od, ov);
      check32($sformatf("rnd%0d_d a=%h b=%h", i, x, y), od, m[31:0]);
      check32($sformatf("rnd%0d_ovf", i), {31'd0, ov}, {31'd0, m[32]});
      check32($sformatf("rnd%0d_lat_le30", i), {31'd0, lat <= 30}, 32'd1);
    end

    // start while busy is ignored
    @(negedge clk);
    a = 32'h40400000;
    b = 32'h3F800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check32("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        ndone++;
        check32("ignore_d", d, 32'h40000000);
      end
      @(posedge clk);
      #1;
    end
    check32("ignore_ndone", 32'(ndone), 32'd1);

    // reset in the middle of a long normalisation
    @(negedge clk);
    a = 32'h3F800001;
    b = 32'h3F800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check32("midrst_busy", {31'd0, busy}, 32'd0);
    check32("midrst_d", d, 32'd0);
    check32("midrst_ovf", {31'd0, overflow}, 32'd0);
    check32("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check32("midrst_nodone", 32'(ndone), 32'd0);
    run_op(32'h40400000, 32'h3F800000, lat, od, ov);
    check32("after_rst_d", od, 32'h40000000);
    check32("after_rst_lat", 32'(lat), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
